turkey_tally: RTL and testbench

Downstream consumer of the turkey-crossing state machine. Turns its crossing pulses (`l_r_count`, `r_l_count`) into a saturating signed net tally, held in sign-magnitude and BCD form for the 7-segment display path. It also runs an idle timer, cleared by the state machine's `reset_timer` and advanced by the quarter-second strobe, which flags when no activity has occurred for a set time.

---
 rtl/turkey_pkg.sv | 48 ++++
 rtl/turkey_tally_if.sv | 34 +++
 rtl/turkey_idle_timer.sv | 47 ++++
 rtl/turkey_tally.sv | 117 +++++++++++
 tb/tb_turkey_tally.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/turkey_pkg.sv
`default_nettype none
// ============================================================================
// Module      : turkey_pkg
// Description : Shared constants, BCD digit type and BCD step helpers for the
//               turkey crossing tally.
// Revision    : 1.0 - initial release
// ============================================================================
package turkey_pkg;

  localparam int DEF_MAX_COUNT  = 99;
  localparam int DEF_IDLE_LIMIT = 4;
  localparam int BCD_W          = 4;
  localparam int MAG_W          = 7;
  localparam int SECS_W         = 4;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd_t;

  // Two-digit BCD +1 with ones-to-tens carry.
  function automatic bcd_t bcd_inc(input bcd_t d);
    bcd_t r;
    r = d;
    if (d.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = d.tens + 4'd1;
    end else begin
      r.ones = d.ones + 4'd1;
    end
    return r;
  endfunction

  // Two-digit BCD -1 with borrow from tens.
  function automatic bcd_t bcd_dec(input bcd_t d);
    bcd_t r;
    r = d;
    if (d.ones == 4'd0) begin
      r.ones = 4'd9;
      r.tens = d.tens - 4'd1;
    end else begin
      r.ones = d.ones - 4'd1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/turkey_tally_if.sv
`default_nettype none
// ============================================================================
// Module      : turkey_tally_if
// Description : Event inputs and tally/idle status outputs of turkey_tally.
// Revision    : 1.0 - initial release
// ============================================================================
interface turkey_tally_if;
  import turkey_pkg::*;

  logic              l_r_count;
  logic              r_l_count;
  logic              reset_timer;
  logic              qsec;
  logic              clr;
  logic              neg;
  logic [MAG_W-1:0]  mag;
  logic [BCD_W-1:0]  tens;
  logic [BCD_W-1:0]  ones;
  logic              sat;
  logic [SECS_W-1:0] idle_secs;
  logic              idle_flag;

  modport master (
    output l_r_count, r_l_count, reset_timer, qsec, clr,
    input  neg, mag, tens, ones, sat, idle_secs, idle_flag
  );

  modport slave (
    input  l_r_count, r_l_count, reset_timer, qsec, clr,
    output neg, mag, tens, ones, sat, idle_secs, idle_flag
  );

endinterface
`default_nettype wire

// File: rtl/turkey_idle_timer.sv
`default_nettype none
// ============================================================================
// Module      : turkey_idle_timer
// Description : Counts quarter-second strobes into whole idle seconds
//               (saturating at 15) and flags when the idle limit is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module turkey_idle_timer
  import turkey_pkg::*;
#(
  parameter int IDLE_LIMIT = DEF_IDLE_LIMIT
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              reset_timer,
  input  wire logic              qsec,
  output logic [SECS_W-1:0]      idle_secs,
  output logic                   idle_flag
);

  localparam logic [SECS_W-1:0] LIMIT    = SECS_W'(IDLE_LIMIT);
  localparam logic [SECS_W-1:0] SECS_MAX = '1;

  logic [1:0]        quarter;
  logic [SECS_W-1:0] secs;

  // Quarter counter and seconds; reset_timer wins over a coincident strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quarter <= 2'd0;
      secs    <= '0;
    end else if (reset_timer) begin
      quarter <= 2'd0;
      secs    <= '0;
    end else if (qsec) begin
      quarter <= quarter + 2'd1;
      if (quarter == 2'd3 && secs != SECS_MAX) begin
        secs <= secs + 1'b1;
      end
    end
  end

  assign idle_secs = secs;
  assign idle_flag = (secs >= LIMIT);

endmodule
`default_nettype wire

// File: rtl/turkey_tally.sv
`default_nettype none
// ============================================================================
// Module      : turkey_tally
// Description : Edge-detects turkey crossing events into a saturating signed
//               net tally kept in sign-magnitude plus incremental BCD, and
//               hosts the idle timer.
// Revision    : 1.0 - initial release
// ============================================================================
module turkey_tally
  import turkey_pkg::*;
#(
  parameter int MAX_COUNT  = DEF_MAX_COUNT,
  parameter int IDLE_LIMIT = DEF_IDLE_LIMIT
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  turkey_tally_if.slave bus
);

  localparam logic [MAG_W-1:0] MAX_MAG = MAG_W'(MAX_COUNT);

  logic             lr_prev;
  logic             rl_prev;
  logic             inc;
  logic             dec;
  logic             neg_q;
  logic             neg_next;
  logic [MAG_W-1:0] mag_q;
  bcd_t             digits_q;
  logic             up;
  logic             down;
  logic [SECS_W-1:0] idle_secs;
  logic             idle_flag;

  // Previous samples of the event inputs; these keep sampling during clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lr_prev <= 1'b0;
      rl_prev <= 1'b0;
    end else begin
      lr_prev <= bus.l_r_count;
      rl_prev <= bus.r_l_count;
    end
  end

  assign inc = bus.l_r_count & ~lr_prev;
  assign dec = bus.r_l_count & ~rl_prev;

  // Reduce the event pair to a magnitude step direction and the next sign.
  always_comb begin
    up       = 1'b0;
    down     = 1'b0;
    neg_next = neg_q;
    if (inc && !dec) begin
      if (neg_q) begin
        down = 1'b1;
        if (mag_q == MAG_W'(1)) neg_next = 1'b0;
      end else begin
        up = 1'b1;
      end
    end else if (dec && !inc) begin
      if (neg_q) begin
        up = 1'b1;
      end else if (mag_q == '0) begin
        up       = 1'b1;
        neg_next = 1'b1;
      end else begin
        down = 1'b1;
      end
    end
    // Growth past the limit is dropped; steps toward zero always apply.
    if (mag_q == MAX_MAG) up = 1'b0;
  end

  // Tally state: magnitude and BCD digits move together, one step per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q    <= 1'b0;
      mag_q    <= '0;
      digits_q <= '0;
    end else if (bus.clr) begin
      neg_q    <= 1'b0;
      mag_q    <= '0;
      digits_q <= '0;
    end else begin
      neg_q <= neg_next;
      if (up) begin
        mag_q    <= mag_q + 1'b1;
        digits_q <= bcd_inc(digits_q);
      end else if (down) begin
        mag_q    <= mag_q - 1'b1;
        digits_q <= bcd_dec(digits_q);
      end
    end
  end

  turkey_idle_timer #(
    .IDLE_LIMIT (IDLE_LIMIT)
  ) u_idle_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .reset_timer (bus.reset_timer),
    .qsec        (bus.qsec),
    .idle_secs   (idle_secs),
    .idle_flag   (idle_flag)
  );

  assign bus.neg       = neg_q;
  assign bus.mag       = mag_q;
  assign bus.tens      = digits_q.tens;
  assign bus.ones      = digits_q.ones;
  assign bus.sat       = (mag_q == MAX_MAG);
  assign bus.idle_secs = idle_secs;
  assign bus.idle_flag = idle_flag;

endmodule
`default_nettype wire

// File: tb/tb_turkey_tally.sv
`default_nettype none
// ============================================================================
// Module      : tb_turkey_tally
// Description : Directed self-checking bench for turkey_tally.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turkey_tally;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  // {neg, mag, tens, ones, sat}
  logic [16:0] got;
  logic [16:0] want;
  // {idle_secs, idle_flag}
  logic [4:0]  igot;
  logic [4:0]  iwant;

  turkey_tally_if bus ();

  turkey_tally #(
    .MAX_COUNT  (99),
    .IDLE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_lr(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); bus.l_r_count = 1'b1;
      @(negedge clk); bus.l_r_count = 1'b0;
    end
  endtask

  task automatic pulse_rl(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); bus.r_l_count = 1'b1;
      @(negedge clk); bus.r_l_count = 1'b0;
    end
  endtask

  task automatic strobe(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); bus.qsec = 1'b1;
      @(negedge clk); bus.qsec = 1'b0;
    end
  endtask

  task automatic do_clr();
    @(negedge clk); bus.clr = 1'b1;
    @(negedge clk); bus.clr = 1'b0;
  endtask

  task automatic test_reset();
    bus.l_r_count = 1'b0; bus.r_l_count = 1'b0; bus.reset_timer = 1'b0;
    bus.qsec = 1'b0; bus.clr = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    got = {bus.neg, bus.mag, bus.tens, bus.ones, bus.sat}; want = '0;
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL reset_tally: got %h want %h", got, want);
    end
    igot = {bus.idle_secs, bus.idle_flag}; iwant = '0;
    vectors++;
    if (igot !== iwant) begin
      miscompares++; $display("FAIL reset_idle: got %h want %h", igot, iwant);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_count_up();
    pulse_lr(3);
    got = {bus.neg, bus.mag, bus.tens, bus.ones, bus.sat};
    want = {1'b0, 7'd3, 4'd0, 4'd3, 1'b0};
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL up3: got %h want %h", got, want);
    end
  endtask

  task automatic test_cross_zero();
    do_clr();
    got = {bus.neg, bus.mag, bus.tens, bus.ones, bus.sat}; want = '0;
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL clr: got %h want %h", got, want);
    end
    pulse_rl(2);
    got = {bus.neg, bus.mag, bus.tens, bus.ones, bus.sat};
    want = {1'b1, 7'd2, 4'd0, 4'd2, 1'b0};
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL neg2: got %h want %h", got, want);
    end
    pulse_lr(2);
    got = {bus.neg, bus.mag, bus.tens, bus.ones, bus.sat}; want = '0;
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL back_to_zero: got %h want %h", got, want);
    end
    pulse_lr(3);
    got = {bus.neg, bus.mag, bus.tens, bus.ones, bus.sat};
    want = {1'b0, 7'd3, 4'd0, 4'd3, 1'b0};
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL pos3: got %h want %h", got, want);
    end
  endtask

  task automatic test_bcd_sat();
    do_clr();
    pulse_lr(9);
    got = {bus.neg, bus.mag, bus.tens, bus.ones, bus.sat};
    want = {1'b0, 7'd9, 4'd0, 4'd9, 1'b0};
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL bcd9: got %h want %h", got, want);
    end
    pulse_lr(1);
    got = {bus.neg, bus.mag, bus.tens, bus.ones, bus.sat};
    want = {1'b0, 7'd10, 4'd1, 4'd0, 1'b0};
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL bcd_carry: got %h want %h", got, want);
    end
    pulse_rl(1);
    got = {bus.neg, bus.mag, bus.tens, bus.ones, bus.sat};
    want = {1'b0, 7'd9, 4'd0, 4'd9, 1'b0};
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL bcd_borrow: got %h want %h", got, want);
    end
    pulse_lr(101);
    got = {bus.neg, bus.mag, bus.tens, bus.ones, bus.sat};
    want = {1'b0, 7'd99, 4'd9, 4'd9, 1'b1};
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL saturate: got %h want %h", got, want);
    end
    pulse_rl(1);
    got = {bus.neg, bus.mag, bus.tens, bus.ones, bus.sat};
    want = {1'b0, 7'd98, 4'd9, 4'd8, 1'b0};
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL unsat98: got %h want %h", got, want);
    end
  endtask

  task automatic test_simul_held_clr();
    do_clr();
    pulse_lr(5);
    @(negedge clk); bus.l_r_count = 1'b1; bus.r_l_count = 1'b1;
    @(negedge clk); bus.l_r_count = 1'b0; bus.r_l_count = 1'b0;
    got = {bus.neg, bus.mag, bus.tens, bus.ones, bus.sat};
    want = {1'b0, 7'd5, 4'd0, 4'd5, 1'b0};
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL simultaneous: got %h want %h", got, want);
    end
    @(negedge clk); bus.l_r_count = 1'b1;
    repeat (10) @(negedge clk);
    bus.l_r_count = 1'b0;
    @(negedge clk);
    got = {bus.neg, bus.mag, bus.tens, bus.ones, bus.sat};
    want = {1'b0, 7'd6, 4'd0, 4'd6, 1'b0};
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL held_level: got %h want %h", got, want);
    end
    @(negedge clk); bus.clr = 1'b1; bus.l_r_count = 1'b1;
    @(negedge clk); bus.clr = 1'b0;
    got = {bus.neg, bus.mag, bus.tens, bus.ones, bus.sat}; want = '0;
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL clr_override: got %h want %h", got, want);
    end
    @(negedge clk);
    got = {bus.neg, bus.mag, bus.tens, bus.ones, bus.sat}; want = '0;
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL clr_no_recount: got %h want %h", got, want);
    end
    bus.l_r_count = 1'b0;
  endtask

  task automatic test_idle();
    @(negedge clk); bus.reset_timer = 1'b1;
    @(negedge clk); bus.reset_timer = 1'b0;
    strobe(15);
    igot = {bus.idle_secs, bus.idle_flag}; iwant = {4'd3, 1'b0};
    vectors++;
    if (igot !== iwant) begin
      miscompares++; $display("FAIL idle15: got %h want %h", igot, iwant);
    end
    strobe(1);
    igot = {bus.idle_secs, bus.idle_flag}; iwant = {4'd4, 1'b1};
    vectors++;
    if (igot !== iwant) begin
      miscompares++; $display("FAIL idle_flag: got %h want %h", igot, iwant);
    end
    strobe(60);
    igot = {bus.idle_secs, bus.idle_flag}; iwant = {4'd15, 1'b1};
    vectors++;
    if (igot !== iwant) begin
      miscompares++; $display("FAIL idle_sat: got %h want %h", igot, iwant);
    end
    @(negedge clk); bus.reset_timer = 1'b1; bus.qsec = 1'b1;
    @(negedge clk); bus.reset_timer = 1'b0; bus.qsec = 1'b0;
    igot = {bus.idle_secs, bus.idle_flag}; iwant = '0;
    vectors++;
    if (igot !== iwant) begin
      miscompares++; $display("FAIL idle_clear: got %h want %h", igot, iwant);
    end
    strobe(3);
    igot = {bus.idle_secs, bus.idle_flag}; iwant = '0;
    vectors++;
    if (igot !== iwant) begin
      miscompares++; $display("FAIL strobe_lost: got %h want %h", igot, iwant);
    end
    strobe(1);
    igot = {bus.idle_secs, bus.idle_flag}; iwant = {4'd1, 1'b0};
    vectors++;
    if (igot !== iwant) begin
      miscompares++; $display("FAIL idle_first_sec: got %h want %h", igot, iwant);
    end
  endtask

  task automatic test_async_reset();
    do_clr();
    pulse_rl(7);
    got = {bus.neg, bus.mag, bus.tens, bus.ones, bus.sat};
    want = {1'b1, 7'd7, 4'd0, 4'd7, 1'b0};
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL neg7: got %h want %h", got, want);
    end
    @(posedge clk);
    #2 rst_n = 1'b0; bus.l_r_count = 1'b1;
    #1;
    got = {bus.neg, bus.mag, bus.tens, bus.ones, bus.sat}; want = '0;
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL async_reset: got %h want %h", got, want);
    end
    igot = {bus.idle_secs, bus.idle_flag}; iwant = '0;
    vectors++;
    if (igot !== iwant) begin
      miscompares++; $display("FAIL async_reset_idle: got %h want %h", igot, iwant);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    got = {bus.neg, bus.mag, bus.tens, bus.ones, bus.sat};
    want = {1'b0, 7'd1, 4'd0, 4'd1, 1'b0};
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL held_through_reset: got %h want %h", got, want);
    end
    repeat (3) @(negedge clk);
    bus.l_r_count = 1'b0;
    got = {bus.neg, bus.mag, bus.tens, bus.ones, bus.sat};
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL held_once: got %h want %h", got, want);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_cross_zero();
    test_bcd_sat();
    test_simul_held_clr();
    test_idle();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
